// File: rtl/sparse_operand_gather.sv
// 2:4 structured-sparse operand gather: pairs each compressed A non-zero with its dense B
// element, and queues the lane pairs in a 2-entry output FIFO with K-tile last marking.
module sparse_operand_gather #(
   parameter int N_MUL   = 4,
   parameter int DW_MUL  = 8,
   parameter int K_BEATS = 4,
   parameter int CW      = $clog2(K_BEATS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [N_MUL*DW_MUL-1:0]   in_a_val,
   input  logic [N_MUL*2-1:0]        in_a_idx,
   input  logic [2*N_MUL*DW_MUL-1:0] in_b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [N_MUL*DW_MUL-1:0]   out_a,
   output logic [N_MUL*DW_MUL-1:0]   out_b,
   output logic                      out_last,
   output logic                      meta_err,
   output logic [CW-1:0]             beat_cnt
);

   localparam int G = N_MUL / 2;
   localparam int W = N_MUL * DW_MUL;

   logic [W-1:0] gat_a_p0;
   logic [W-1:0] gat_b_p0;
   logic         err_p0;
   logic         last_p0;
   logic         vld_p0;

   logic [W-1:0] skid_a_p1;
   logic [W-1:0] skid_b_p1;
   logic         skid_last_p1;

   logic [1:0]   count;
   logic         pop;
   logic         load_in;
   logic         load_skid;
   logic         skid_wr;

   function automatic logic signed [DW_MUL-1:0] pick_b(input logic [2*W-1:0] b,
                                                       input int g,
                                                       input logic [1:0] idx);
      return b[(4*g + int'(idx))*DW_MUL +: DW_MUL];
   endfunction

   function automatic logic signed [DW_MUL-1:0] pick_a(input logic [W-1:0] a, input int j);
      return a[j*DW_MUL +: DW_MUL];
   endfunction

   // ---- stage p0: combinational gather and metadata check on the input beat
   always_comb begin
      gat_a_p0 = '0;
      gat_b_p0 = '0;
      err_p0   = 1'b0;
      for (int g = 0; g < G; g++) begin
         // a group with non-increasing positions is zeroed rather than half-gathered
         if (in_a_idx[4*g +: 2] < in_a_idx[4*g+2 +: 2]) begin
            for (int k = 0; k < 2; k++) begin
               gat_a_p0[(2*g+k)*DW_MUL +: DW_MUL] = pick_a(in_a_val, 2*g + k);
               gat_b_p0[(2*g+k)*DW_MUL +: DW_MUL] = pick_b(in_b, g, in_a_idx[(2*g+k)*2 +: 2]);
            end
         end else begin
            err_p0 = 1'b1;
         end
      end
   end

   assign last_p0   = (beat_cnt == CW'(K_BEATS - 1));
   assign in_ready  = enable & ~reset & (count != 2'd2);
   assign out_valid = enable & (count != 2'd0);
   assign vld_p0    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // head register is the output; skid holds the second entry only when two are queued
   assign load_in   = vld_p0 & ((count == 2'd0) | ((count == 2'd1) & pop));
   assign load_skid = pop & (count == 2'd2);
   assign skid_wr   = vld_p0 & (count == 2'd1) & ~pop;

   // ---- stage p1: FIFO head/skid registers and tile/error control
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count    <= 2'd0;
         beat_cnt <= '0;
         meta_err <= 1'b0;
         out_a    <= '0;
         out_b    <= '0;
         out_last <= 1'b0;
      end else begin
         if (vld_p0) begin
            beat_cnt <= last_p0 ? '0 : beat_cnt + CW'(1);
            if (err_p0) meta_err <= 1'b1;
         end
         if (vld_p0 && !pop)      count <= count + 2'd1;
         else if (!vld_p0 && pop) count <= count - 2'd1;
         if (load_in) begin
            out_a    <= gat_a_p0;
            out_b    <= gat_b_p0;
            out_last <= last_p0;
         end else if (load_skid) begin
            out_a    <= skid_a_p1;
            out_b    <= skid_b_p1;
            out_last <= skid_last_p1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (skid_wr) begin
         skid_a_p1    <= gat_a_p0;
         skid_b_p1    <= gat_b_p0;
         skid_last_p1 <= last_p0;
      end
   end

endmodule

// File: tb/tb_sparse_operand_gather.sv
// Directed bench for sparse_operand_gather: scoreboard of expected FIFO entries plus a
// reference model of the handshake, tile counter and metadata flag.
module tb_sparse_operand_gather;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int K  = 4;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        last;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a_val = '0;
   logic [7:0]  in_a_idx = '0;
   logic [63:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic        out_last;
   logic        meta_err;
   logic [1:0]  beat_cnt;

   int   total = 0;
   int   bad = 0;
   ent_t sb[$];
   ent_t last_e = '0;
   int   exp_cnt = 0;
   logic exp_err = 1'b0;
   logic accepted = 1'b0;
   int   n_last = 0;
   int   n_pop = 0;

   sparse_operand_gather #(.N_MUL(N), .DW_MUL(DW), .K_BEATS(K)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a_val(in_a_val), .in_a_idx(in_a_idx), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_last(out_last),
      .meta_err(meta_err), .beat_cnt(beat_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t model(input logic [31:0] av, input logic [7:0] ai,
                                  input logic [63:0] b, input logic lst, output logic err);
      ent_t e;
      e      = '0;
      e.last = lst;
      err    = 1'b0;
      for (int g = 0; g < 2; g++) begin
         if (ai[4*g +: 2] < ai[4*g+2 +: 2]) begin
            for (int k = 0; k < 2; k++) begin
               int j;
               int p;
               j = 2*g + k;
               p = 4*g + int'(ai[2*j +: 2]);
               e.a[8*j +: 8] = av[8*j +: 8];
               e.b[8*j +: 8] = b[8*p +: 8];
            end
         end else begin
            err = 1'b1;
         end
      end
      return e;
   endfunction

   // one clock: check outputs against the model at negedge, then advance the model
   task automatic cycle();
      logic e_ir, e_ov, push, pop, err;
      ent_t e;
      @(negedge clk);
      if (reset) begin
         sb.delete();
         exp_cnt = 0;
         exp_err = 1'b0;
         last_e  = '0;
      end
      e_ir = enable && !reset && (sb.size() < 2);
      e_ov = enable && !reset && (sb.size() > 0);
      chk("in_ready", in_ready, e_ir);
      chk("out_valid", out_valid, e_ov);
      chk("beat_cnt", beat_cnt, exp_cnt);
      chk("meta_err", meta_err, exp_err);
      if (sb.size() > 0) begin
         chk("head_a", out_a, sb[0].a);
         chk("head_b", out_b, sb[0].b);
         chk("head_last", out_last, sb[0].last);
      end else begin
         chk("hold_a", out_a, last_e.a);
         chk("hold_b", out_b, last_e.b);
         chk("hold_last", out_last, last_e.last);
      end
      push = in_valid && e_ir;
      pop  = e_ov && out_ready;
      accepted = push;
      if (pop) begin
         last_e = sb.pop_front();
         n_pop++;
         if (last_e.last) n_last++;
      end
      if (push) begin
         e = model(in_a_val, in_a_idx, in_b, exp_cnt == K-1, err);
         sb.push_back(e);
         if (err) exp_err = 1'b1;
         exp_cnt = (exp_cnt + 1) % K;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic [7:0] v);
      in_a_val = {4{v}};
      in_b     = {8{v}};
      in_a_idx = 8'hE4;
   endtask

   task automatic set_rand();
      int lo, hi;
      in_a_val = $urandom;
      in_b     = {$urandom, $urandom};
      for (int g = 0; g < 2; g++) begin
         lo = $urandom_range(0, 2);
         hi = $urandom_range(lo + 1, 3);
         in_a_idx[4*g +: 2]   = 2'(lo);
         in_a_idx[4*g+2 +: 2] = 2'(hi);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      int n0, p0;
      logic done;

      // reset with a beat offered
      enable = 1'b1;
      in_valid = 1'b1;
      set_beat(8'h55);
      #1 reset = 1'b1;
      cycle();
      cycle();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_a", out_a, 0);
      reset = 1'b0;
      in_valid = 1'b0;
      cycle();

      // gather
      in_b     = 64'hFCFD_FEFF_281E_140A;
      in_a_val = 32'h0504_0302;
      in_a_idx = 8'hD8;
      out_ready = 1'b1;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("gather_valid", out_valid, 1);
      chk("gather_a", out_a, 32'h0504_0302);
      chk("gather_b", out_b, 32'hFCFE_1E0A);
      cycle();

      // metadata error on group 1
      in_a_val = 32'h0B0A_0907;
      in_a_idx = 8'hF4;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("meta_a", out_a, 32'h0000_0907);
      chk("meta_b", out_b, 32'h0000_140A);
      cycle();
      chk("meta_set", meta_err, 1);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_rand();
         cycle();
      end
      in_valid = 1'b0;
      cycle();
      chk("meta_sticky", meta_err, 1);

      // backpressure
      do_reset();
      chk("meta_cleared", meta_err, 0);
      p0 = n_pop;
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int v = 1; v <= 3; v++) begin
         set_beat(8'(v));
         cycle();
      end
      chk("bp_full", in_ready, 0);
      out_ready = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 6 && !done; i++) begin
         cycle();
         if (accepted) done = 1'b1;
      end
      chk("bp_accept3", done, 1);
      in_valid = 1'b0;
      for (int i = 0; i < 6 && sb.size() > 0; i++) cycle();
      chk("bp_drained", sb.size(), 0);
      chk("bp_pops", n_pop - p0, 3);
      chk("bp_last_val", out_a, 32'h0303_0303);

      // tile marking
      do_reset();
      n0 = n_last;
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_rand();
         chk("tile_cnt", beat_cnt, i % K);
         cycle();
      end
      in_valid = 1'b0;
      cycle();
      chk("tile_cnt_end", beat_cnt, 0);
      chk("tile_lasts", n_last - n0, 2);

      // enable drop mid-tile, then reset mid-tile
      do_reset();
      in_valid = 1'b1;
      set_rand();
      cycle();
      set_rand();
      cycle();
      out_ready = 1'b0;
      set_rand();
      cycle();
      enable = 1'b0;
      out_ready = 1'b1;
      set_rand();
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("en_hold_cnt", beat_cnt, 3);
         chk("en_no_ready", in_ready, 0);
      end
      enable = 1'b1;
      cycle();
      cycle();
      in_valid = 1'b0;
      cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("rst_mid_cnt", beat_cnt, 0);
      in_valid = 1'b1;
      set_rand();
      cycle();
      in_valid = 1'b0;
      chk("rst_mid_valid", out_valid, 1);
      chk("rst_mid_last", out_last, 0);
      cycle();
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sparse_operand_gather.md
Name: sparse_operand_gather

Overview:
Upstream feeder for dp_unit in the sparse tensor core. Takes 2:4 structured-sparse A operands (compressed non-zeros plus 2-bit position metadata) and a dense B row segment. Gathers the B elements that match each A non-zero, producing N_MUL aligned (a, b) lane pairs per beat. Buffers results in a 2-entry output FIFO with valid/ready handshake and marks the last beat of each K tile.

Parameters:
N_MUL, 4, output lanes (must be even); groups G = N_MUL/2, each group = 4 dense B positions holding 2 non-zeros
DW_MUL, 8, signed element width of A and B
K_BEATS, 4, beats per K tile (must be >= 2); counter width CW = clog2(K_BEATS)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  global run enable; low freezes the block
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_a_val  in  N_MUL*DW_MUL  compressed A non-zeros; lane j at [j*DW_MUL +: DW_MUL]; lanes 2g, 2g+1 belong to group g
in_a_idx  in  N_MUL*2  position (0..3) of lane j inside its group, at [j*2 +: 2]
in_b  in  2*N_MUL*DW_MUL  dense B; element 4g+p at [(4g+p)*DW_MUL +: DW_MUL]
out_valid  out  1  output beat valid
out_ready  in  1  consumer ready
out_a  out  N_MUL*DW_MUL  A lane values, same packing as in_a_val
out_b  out  N_MUL*DW_MUL  gathered B lane values, same packing
out_last  out  1  beat is the final beat of a K tile
meta_err  out  1  sticky metadata-error flag
beat_cnt  out  CW  index within the tile of the next accepted beat

Behaviour:
- Reset (async, active-high): FIFO count=0, beat_cnt=0, meta_err=0, out_valid=0, out_a/out_b/out_last=0, in_ready=0 while reset is asserted.
- Gather (combinational on the input side): out_a lane j = in_a_val lane j. out_b lane j = in_b element 4*(j/2) + in_a_idx[j]. All values pass through unchanged, with no arithmetic.
- Metadata check per group g: idx[2g] < idx[2g+1] is required (strictly increasing). Zero padding uses a value of 0 at a distinct index.
- On a violation: lanes 2g and 2g+1 of both out_a and out_b are forced to 0 for that beat. meta_err is set on acceptance of the beat. The beat is still accepted and counted. meta_err clears only on reset.
- Handshake: push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = enable & (count < 2).
  - out_valid = enable & (count > 0).
  - FIFO is 2 entries, in order. Each entry holds {a, b, last}.
- Latency: an accepted beat is visible on the outputs in the next cycle when the FIFO was empty, or behind older entries otherwise.
- Throughput: 1 beat/cycle when out_ready is held high. Push and pop in the same cycle keeps count unchanged. A push at count=2 cannot occur.
- Outputs present the head entry. When count=0, out_a, out_b and out_last hold their last values, and out_valid=0.
- Tile counter:
  - On each push, the entry's last = (beat_cnt == K_BEATS-1).
  - beat_cnt then increments, wrapping K_BEATS-1 -> 0.
  - Pops do not affect beat_cnt.
- enable=0: no push, no pop, all state held, in_ready=0, out_valid=0. On re-enable, operation resumes with the same FIFO contents and beat_cnt.
- Reset mid-tile: FIFO contents are discarded and beat_cnt returns to 0. The next accepted beat is beat 0.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_a=out_b=0, beat_cnt=0, meta_err=0.
- Gather: B elements 0..7 = {10,20,30,40,-1,-2,-3,-4}, in_a_val = {2,3,4,5}, in_a_idx = {0,2,1,3}, out_ready=1 -> one cycle later out_valid=1, out_a={2,3,4,5}, out_b={10,30,-2,-4}.
- Metadata error: group 1 indices = {3,3}, group 0 indices = {0,1} -> out_a={a0,a1,0,0}, out_b={10,20,0,0}. meta_err=1 and stays 1 through 5 further clean beats until reset.
- Backpressure: out_ready=0 while offering 3 beats (values 1,2,3) -> in_ready drops after 2 accepts. Raise out_ready -> outputs 1, 2, then beat 3 is accepted and emitted. No loss, no duplication.
- Tile marking: K_BEATS=4, 8 back-to-back beats with out_ready=1 -> out_last=1 on output beats 4 and 8 only; beat_cnt sequence 0,1,2,3,0,1,2,3,0.
- Enable and reset mid-tile: drop enable for 3 cycles after beat 2 of a tile -> no handshakes occur, and state is held. Then pulse reset after beat 3 -> next beat has beat_cnt=0 and out_last=0.
